// File: rtl/core_obi_arbiter.sv
// Two-to-one OBI arbiter merging instruction-fetch and data ports onto one memory port.
// Round-robin on ties, request held stable until granted, in-order ID FIFO routes responses.
module core_obi_arbiter #(
   parameter int unsigned MaxTrans = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   output logic        busy_o
);

   localparam int unsigned CntW = $clog2(MaxTrans + 1);
   localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

   typedef enum logic {
      PORT_INSTR = 1'b0,
      PORT_DATA  = 1'b1
   } port_e;

   port_e            last_win, lock_sel, sel, head;
   logic             lock;
   port_e            fifo_q [MaxTrans];
   logic [PtrW-1:0]  wptr, rptr;
   logic [CntW-1:0]  cnt;
   logic             full, handshake, pop;

   assign full = (cnt == CntW'(MaxTrans));

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      sel = port_e'(~last_win);
      if (lock) begin
         sel = lock_sel;
      end else if (instr_req_i && !data_req_i) begin
         sel = PORT_INSTR;
      end else if (data_req_i && !instr_req_i) begin
         sel = PORT_DATA;
      end
   end

   // A full FIFO blocks requests even when a pop lands in the same cycle.
   assign mem_req_o = (instr_req_i | data_req_i) & ~full;
   assign handshake = mem_req_o & mem_gnt_i;

   assign mem_we_o    = (sel == PORT_DATA) ? data_we_i    : 1'b0;
   assign mem_be_o    = (sel == PORT_DATA) ? data_be_i    : 4'hF;
   assign mem_addr_o  = (sel == PORT_DATA) ? data_addr_i  : instr_addr_i;
   assign mem_wdata_o = (sel == PORT_DATA) ? data_wdata_i : 32'h0;

   assign instr_gnt_o = handshake & (sel == PORT_INSTR);
   assign data_gnt_o  = handshake & (sel == PORT_DATA);

   // Responses with nothing outstanding are dropped.
   assign pop  = mem_rvalid_i & (cnt != '0);
   assign head = fifo_q[rptr];

   assign instr_rvalid_o = pop & (head == PORT_INSTR);
   assign data_rvalid_o  = pop & (head == PORT_DATA);
   assign instr_rdata_o  = mem_rdata_i;
   assign data_rdata_o   = mem_rdata_i;
   assign instr_err_o    = mem_err_i;
   assign data_err_o     = mem_err_i;

   assign busy_o = (cnt != '0) | instr_req_i | data_req_i;

   // NOTE: state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_win <= PORT_DATA;
         lock     <= 1'b0;
         lock_sel <= PORT_INSTR;
         wptr     <= '0;
         rptr     <= '0;
         cnt      <= '0;
      end else begin
         if (handshake) begin
            lock     <= 1'b0;
            last_win <= sel;
            wptr     <= (wptr == PtrW'(MaxTrans - 1)) ? '0 : wptr + 1'b1;
         end else if (mem_req_o) begin
            lock     <= 1'b1;
            lock_sel <= sel;
         end
         if (pop) begin
            rptr <= (rptr == PtrW'(MaxTrans - 1)) ? '0 : rptr + 1'b1;
         end
         case ({handshake, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // NOTE: FIFO storage is not reset; entries are only read below cnt, which is reset.
   always_ff @(posedge clk_i) begin
      if (handshake) begin
         fifo_q[wptr] <= sel;
      end
   end

endmodule

// File: tb/tb_core_obi_arbiter.sv
// Directed self-checking bench for core_obi_arbiter (MaxTrans = 2).
module tb_core_obi_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i, data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i;
   logic        data_gnt_o, data_rvalid_o, data_err_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
   logic [31:0] mem_rdata_i;
   logic        busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   core_obi_arbiter #(.MaxTrans(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance one edge, then settle 1 time unit before driving new inputs.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      instr_req_i = 0; instr_addr_i = 32'h0;
      data_req_i = 0; data_we_i = 0; data_be_i = 4'h0; data_addr_i = 32'h0; data_wdata_i = 32'h0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 32'h0; mem_err_i = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_i = 1;
      tick();
      tick();
      rst_i = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++;
      if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, busy_o} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected 000000",
                  {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, busy_o});
      end
   endtask

   task automatic test_single_instr();
      do_reset();
      instr_req_i = 1; instr_addr_i = 32'h1000_0080; mem_gnt_i = 1;
      #1;
      n_checks++;
      if ({mem_req_o, mem_we_o, mem_be_o, instr_gnt_o, data_gnt_o} !== 8'b1_0_1111_1_0) begin
         n_fail++;
         $display("FAIL single_req: got %b expected 10111110",
                  {mem_req_o, mem_we_o, mem_be_o, instr_gnt_o, data_gnt_o});
      end
      n_checks++;
      if (mem_addr_o !== 32'h1000_0080) begin
         n_fail++;
         $display("FAIL single_addr: got %h expected 10000080", mem_addr_o);
      end
      tick();
      instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
      #1;
      n_checks++;
      if ({instr_rvalid_o, data_rvalid_o, instr_rdata_o} !== {2'b10, 32'hDEAD_BEEF}) begin
         n_fail++;
         $display("FAIL single_resp: got %b %b %h expected 1 0 deadbeef",
                  instr_rvalid_o, data_rvalid_o, instr_rdata_o);
      end
      tick();
      mem_rvalid_i = 0;
      #1;
      n_checks++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle: busy got %b expected 0", busy_o);
      end
   endtask

   task automatic test_tie_alternation();
      logic exp_gnt_data, prev_data;
      do_reset();
      instr_req_i = 1; instr_addr_i = 32'hA000_0000;
      data_req_i = 1; data_addr_i = 32'hB000_0000; data_be_i = 4'h3;
      mem_gnt_i = 1;
      prev_data = 0;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin
            instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0;
         end
         mem_rvalid_i = (k > 0);
         mem_rdata_i  = 32'h100 + k;
         #1;
         exp_gnt_data = (k % 2 == 1);
         if (k < 4) begin
            n_checks++;
            if ({instr_gnt_o, data_gnt_o} !== {~exp_gnt_data, exp_gnt_data}) begin
               n_fail++;
               $display("FAIL tie_gnt[%0d]: got i=%b d=%b expected i=%b d=%b", k,
                        instr_gnt_o, data_gnt_o, ~exp_gnt_data, exp_gnt_data);
            end
            n_checks++;
            if (mem_addr_o !== (exp_gnt_data ? 32'hB000_0000 : 32'hA000_0000)) begin
               n_fail++;
               $display("FAIL tie_addr[%0d]: got %h", k, mem_addr_o);
            end
         end
         if (k > 0) begin
            n_checks++;
            if ({instr_rvalid_o, data_rvalid_o} !== {~prev_data, prev_data}) begin
               n_fail++;
               $display("FAIL tie_resp[%0d]: got i=%b d=%b expected i=%b d=%b", k,
                        instr_rvalid_o, data_rvalid_o, ~prev_data, prev_data);
            end
         end
         prev_data = exp_gnt_data;
         tick();
      end
      mem_rvalid_i = 0;
      #1;
      n_checks++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL tie_idle: busy got %b expected 0", busy_o);
      end
   endtask

   task automatic test_lock();
      do_reset();
      data_req_i = 1; data_we_i = 1; data_addr_i = 32'h2000_0000;
      data_wdata_i = 32'h1234_5678; data_be_i = 4'b0011;
      instr_addr_i = 32'h3000_0004;
      for (int c = 1; c <= 3; c++) begin
         if (c == 2) instr_req_i = 1;
         #1;
         n_checks++;
         if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, instr_gnt_o, data_gnt_o}
             !== {1'b1, 1'b1, 4'b0011, 32'h2000_0000, 32'h1234_5678, 2'b00}) begin
            n_fail++;
            $display("FAIL lock_hold[%0d]: req=%b we=%b be=%b addr=%h wdata=%h ig=%b dg=%b", c,
                     mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, instr_gnt_o, data_gnt_o);
         end
         tick();
      end
      mem_gnt_i = 1;
      #1;
      n_checks++;
      if ({data_gnt_o, instr_gnt_o, mem_addr_o} !== {2'b10, 32'h2000_0000}) begin
         n_fail++;
         $display("FAIL lock_data_gnt: dg=%b ig=%b addr=%h expected 1 0 20000000",
                  data_gnt_o, instr_gnt_o, mem_addr_o);
      end
      tick();
      data_req_i = 0;
      #1;
      n_checks++;
      if ({instr_gnt_o, data_gnt_o, mem_we_o, mem_addr_o} !== {3'b100, 32'h3000_0004}) begin
         n_fail++;
         $display("FAIL lock_instr_next: ig=%b dg=%b we=%b addr=%h expected 1 0 0 30000004",
                  instr_gnt_o, data_gnt_o, mem_we_o, mem_addr_o);
      end
      tick();
      instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
      #1;
      n_checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL lock_resp0: got i=%b d=%b expected i=0 d=1", instr_rvalid_o, data_rvalid_o);
      end
      tick();
      #1;
      n_checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL lock_resp1: got i=%b d=%b expected i=1 d=0", instr_rvalid_o, data_rvalid_o);
      end
      tick();
      mem_rvalid_i = 0;
   endtask

   task automatic test_full_fifo();
      do_reset();
      instr_req_i = 1; instr_addr_i = 32'h0000_0040; mem_gnt_i = 1;
      tick();
      tick();
      #1;
      n_checks++;
      if ({mem_req_o, instr_gnt_o, busy_o} !== 3'b001) begin
         n_fail++;
         $display("FAIL full_block: req=%b ig=%b busy=%b expected 0 0 1", mem_req_o, instr_gnt_o, busy_o);
      end
      tick();
      mem_rvalid_i = 1;
      #1;
      n_checks++;
      if ({mem_req_o, instr_gnt_o, instr_rvalid_o} !== 3'b001) begin
         n_fail++;
         $display("FAIL full_pop_same_cycle: req=%b ig=%b irv=%b expected 0 0 1",
                  mem_req_o, instr_gnt_o, instr_rvalid_o);
      end
      tick();
      mem_rvalid_i = 0;
      #1;
      n_checks++;
      if ({mem_req_o, instr_gnt_o} !== 2'b11) begin
         n_fail++;
         $display("FAIL full_regrant: req=%b ig=%b expected 1 1", mem_req_o, instr_gnt_o);
      end
      tick();
      instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
      tick();
      tick();
      mem_rvalid_i = 0;
      #1;
      n_checks++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL full_drain: busy got %b expected 0", busy_o);
      end
   endtask

   task automatic test_spurious_reset();
      do_reset();
      data_req_i = 1; data_we_i = 0; data_addr_i = 32'h4000_0000; mem_gnt_i = 1;
      tick();
      data_req_i = 0; mem_gnt_i = 0; rst_i = 1;
      tick();
      rst_i = 0; mem_rvalid_i = 1; mem_err_i = 1;
      #1;
      n_checks++;
      if ({instr_rvalid_o, data_rvalid_o, busy_o} !== 3'b000) begin
         n_fail++;
         $display("FAIL spurious_drop: irv=%b drv=%b busy=%b expected 0 0 0",
                  instr_rvalid_o, data_rvalid_o, busy_o);
      end
      tick();
      mem_rvalid_i = 0; mem_err_i = 0;
      #1;
      n_checks++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL spurious_state: busy got %b expected 0", busy_o);
      end
   endtask

   task automatic test_error_routing();
      do_reset();
      data_req_i = 1; data_addr_i = 32'h5000_0010; mem_gnt_i = 1;
      tick();
      data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_err_i = 1;
      #1;
      n_checks++;
      if ({data_rvalid_o, data_err_o, instr_rvalid_o} !== 3'b110) begin
         n_fail++;
         $display("FAIL err_route: drv=%b derr=%b irv=%b expected 1 1 0",
                  data_rvalid_o, data_err_o, instr_rvalid_o);
      end
      tick();
      mem_rvalid_i = 0; mem_err_i = 0;
      #1;
      n_checks++;
      if ({data_rvalid_o, data_err_o, instr_rvalid_o} !== 3'b000) begin
         n_fail++;
         $display("FAIL err_one_cycle: drv=%b derr=%b irv=%b expected 0 0 0",
                  data_rvalid_o, data_err_o, instr_rvalid_o);
      end
   endtask

   initial begin
      clear_inputs();
      rst_i = 1;
      test_reset();
      test_single_instr();
      test_tie_alternation();
      test_lock();
      test_full_fifo();
      test_spurious_reset();
      test_error_routing();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/core_obi_arbiter.md
# core_obi_arbiter

Two-to-one OBI arbiter that merges the core's instruction-fetch and data ports onto a single shared memory-side OBI port. It sits between the core wrapper and the bus or SRAM bank. Each cycle it chooses one requester by round-robin, and it holds that choice stable until the grant arrives. It records the owner of every accepted transaction in an in-order ID FIFO so that responses go back to the correct requester.

## Interface
Parameters:
- `MaxTrans`, default 2: maximum outstanding accepted transactions (ID FIFO depth), 1..8.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `instr_req_i` in 1: instruction request.
- `instr_addr_i` in 32: instruction address.
- `instr_gnt_o` out 1: instruction grant.
- `instr_rvalid_o` out 1: instruction response valid.
- `instr_rdata_o` out 32: instruction read data.
- `instr_err_o` out 1: instruction error.
- `data_req_i` in 1: data request.
- `data_we_i` in 1: data write enable.
- `data_be_i` in 4: data byte enables.
- `data_addr_i` in 32: data address.
- `data_wdata_i` in 32: data write data.
- `data_gnt_o` out 1: data grant.
- `data_rvalid_o` out 1: data response valid.
- `data_rdata_o` out 32: data read data.
- `data_err_o` out 1: data error.
- `mem_req_o` out 1: merged request.
- `mem_we_o` out 1: merged write enable.
- `mem_be_o` out 4: merged byte enables.
- `mem_addr_o` out 32: merged address.
- `mem_wdata_o` out 32: merged write data.
- `mem_gnt_i` in 1: memory grant.
- `mem_rvalid_i` in 1: memory response valid.
- `mem_rdata_i` in 32: memory read data.
- `mem_err_i` in 1: memory error.
- `busy_o` out 1: high while any transaction is outstanding or any request is pending.

## Operation
- Arbitration state:
  - `last_win` (0 = instr, 1 = data).
  - `lock` and `lock_sel`.
  - ID FIFO, `MaxTrans` entries of 1 bit, with count `cnt` of width $clog2(MaxTrans+1).
- Selection:
  - If `lock` is set, the selected port is `lock_sel`.
  - Otherwise, with a single requester, that requester wins.
  - Otherwise, with both requesting, the port that is not `last_win` wins.
- Request forwarding:
  - `mem_req_o` = (instr_req_i | data_req_i) & (cnt != MaxTrans).
  - When `cnt == MaxTrans`, `mem_req_o` = 0 and both grants are 0.
- Mux, instr selected: `mem_we_o`=0, `mem_be_o`=4'hF, `mem_addr_o`=instr_addr_i, `mem_wdata_o`=0.
- Mux, data selected: the data fields pass through.
- Grant: `gnt` of the selected port = mem_gnt_i & mem_req_o. The unselected port's grant is 0.
- Lock:
  - Set when mem_req_o & !mem_gnt_i, with `lock_sel` = selected port.
  - Cleared on the handshake (mem_req_o & mem_gnt_i).
  - This makes the memory side observe OBI-stable address and data.
- On handshake:
  - Push the selected ID into the FIFO.
  - Set `last_win` = selected port.
- Responses:
  - On mem_rvalid_i with cnt != 0, the head ID selects the target.
  - The target gets rvalid, rdata and err. The head is popped.
  - The other port's rvalid is 0.
  - rdata and err are driven to both ports unconditionally; only rvalid is steered.
- Spurious response: mem_rvalid_i with cnt == 0 is dropped. No rvalid is asserted and no state changes.
- Push and pop in the same cycle: cnt unchanged, and the pointers advance with wrap-around modulo MaxTrans.
- A full FIFO blocks grants in that cycle even if a pop occurs in the same cycle. This is deterministic and avoids a comb path from mem_rvalid_i to mem_req_o.
- `busy_o` = (cnt != 0) | instr_req_i | data_req_i.

## Timing
- Zero-cycle request path: mem_req_o, mux fields and grants are combinational from the inputs and the registered state.
- Zero-cycle response path: rvalid, rdata and err are combinational from mem_* and the FIFO head.
- No combinational path from mem_rvalid_i to mem_req_o or to any grant.
- State updates on the rising `clk_i` edge.
- Reset (`rst_i`=1 at an edge):
  - Clears cnt, the FIFO pointers and `lock`.
  - Sets `last_win` = 1, so instr wins the first tie.
- Outputs during and after reset: mem_req_o=0 and rvalid outputs=0 unless inputs request.
- Reset mid-transaction: outstanding IDs are discarded. Later mem_rvalid_i pulses count as spurious and are dropped.
- Throughput: one grant per cycle when mem_gnt_i is held high and cnt < MaxTrans.

## Test plan
- **Single instr read.** instr_req_i=1, addr=0x1000_0080, mem_gnt_i=1 → same cycle: mem_req_o=1, mem_we_o=0, mem_be_o=4'hF, instr_gnt_o=1. mem_rvalid_i next cycle with rdata=0xDEAD_BEEF → instr_rvalid_o=1, instr_rdata_o=0xDEAD_BEEF, data_rvalid_o=0.
- **Tie alternation.** Both ports request continuously, mem_gnt_i=1, rvalid one cycle later → grants alternate I, D, I, D from reset. Responses are routed in the same order.
- **Lock.**
  - Step 1: data request write 0x2000_0000 / 0x1234_5678 / be 4'b0011 with mem_gnt_i=0 for 3 cycles. Instr asserts req on cycle 2 → mem_addr_o stays 0x2000_0000 and instr_gnt_o=0 until the data grant.
  - Step 2: the next cycle grants instr.
- **Full FIFO (MaxTrans=2).** Two grants with no rvalid → third request sees mem_req_o=0. rvalid arriving in the same cycle → still no grant that cycle; the grant comes the following cycle.
- **Spurious and reset.**
  - Step 1: one outstanding data read, then rst_i pulsed for 1 cycle.
  - Step 2: mem_rvalid_i=1 afterwards, mem_err_i=1 → no rvalid on either port, cnt=0, busy_o=0.
- **Error routing.** Data read answered with mem_err_i=1 → data_rvalid_o=1 and data_err_o=1 for exactly 1 cycle. instr_rvalid_o stays 0.
